// File: rtl/eq_seq_ctrl.sv
// eq_seq_ctrl: sequential nibble-by-nibble equality scanner.
// On an accepted start it captures two 16-bit operands and a nibble count,
// then presents one nibble pair per cycle to an external 4-bit equality
// comparator. It reports whether all selected nibbles matched and the index
// of the lowest mismatching nibble.
//
// Parameters:
//   EARLY_EXIT  1 = stop at the first mismatch, 0 = always scan every nibble
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   start        request a comparison (accepted only when idle)
//   a, b         16-bit operands, nibble k = bits [4k+3:4k]
//   len          number of nibbles to compare minus 1
//   cmp_a/cmp_b  nibble pair to the external comparator (0 when not scanning)
//   cmp_eq       combinational comparator result for cmp_a/cmp_b
//   busy         high while scanning
//   done         one-cycle pulse when eq/mis_idx become valid
//   eq           1 = all compared nibbles equal
//   mis_idx      lowest mismatching nibble index (0 when eq = 1)
module eq_seq_ctrl #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [1:0]  len,
  output logic [3:0]  cmp_a,
  output logic [3:0]  cmp_b,
  input  logic        cmp_eq,
  output logic        busy,
  output logic        done,
  output logic        eq,
  output logic [1:0]  mis_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] a_r, b_r;
  logic [1:0]  len_r;
  logic [1:0]  idx;
  logic        match;       // sticky: cleared on the first mismatch
  logic        last_nib;
  logic        stop_early;

  assign last_nib   = (idx == len_r);
  assign stop_early = EARLY_EXIT && !cmp_eq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    cmp_a     = '0;
    cmp_b     = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CMP;
      end
      CMP: begin
        busy  = 1'b1;
        cmp_a = a_r[{idx, 2'b00} +: 4];
        cmp_b = b_r[{idx, 2'b00} +: 4];
        if (stop_early || last_nib) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r     <= '0;
      b_r     <= '0;
      len_r   <= '0;
      idx     <= '0;
      match   <= 1'b0;
      eq      <= 1'b0;
      mis_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            len_r   <= len;
            idx     <= '0;
            match   <= 1'b1;
            eq      <= 1'b0;
            mis_idx <= '0;
          end
        end
        CMP: begin
          // match is still 1 only before the first mismatch, so it doubles
          // as the "first mismatch not yet recorded" flag in full-scan mode.
          if (!cmp_eq) begin
            match <= 1'b0;
            if (EARLY_EXIT || match) mis_idx <= idx;
          end
          if (stop_early) begin
            eq <= 1'b0;
          end else if (last_nib) begin
            eq <= match & cmp_eq;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/eq_seq_ctrl.md
EQ_SEQ_CTRL -- requirements
Module: eq_seq_ctrl

Interface
REQ-001 The block SHALL have parameter EARLY_EXIT, default 1: 1 = stop at the first nibble mismatch; 0 = always scan every selected nibble.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 The block SHALL have port start, input, 1 bit: request a comparison; accepted only in IDLE.
REQ-005 The block SHALL have ports a and b, input, 16 bits each: operands; nibble k = bits [4k+3:4k].
REQ-006 The block SHALL have port len, input, 2 bits: number of nibbles to compare minus 1 (0 to 3).
REQ-007 The block SHALL have ports cmp_a and cmp_b, output, 4 bits each: nibble pair driven to the external 4-bit equality comparator.
REQ-008 The block SHALL have port cmp_eq, input, 1 bit: comparator result, combinational from cmp_a/cmp_b, valid within the same cycle.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in CMP.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result becomes valid.
REQ-011 The block SHALL have port eq, output, 1 bit: result, 1 = all compared nibbles equal.
REQ-012 The block SHALL have port mis_idx, output, 2 bits: index of the lowest mismatching nibble (0 when eq=1).

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, CMP, DONE.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL register a, b and len, clear its nibble index to 0, and enter CMP.
REQ-015 In CMP, the block SHALL drive cmp_a/cmp_b from registered nibble[idx] and sample cmp_eq at the next rising edge.
REQ-016 In CMP, on a sampled mismatch with EARLY_EXIT=1, the block SHALL set eq=0, set mis_idx=idx, and enter DONE.
REQ-017 On a mismatch with EARLY_EXIT=0, the block SHALL latch mis_idx only for the first mismatch, clear a sticky match flag, and continue scanning.
REQ-018 When idx equals the registered len and no early exit has occurred, the block SHALL enter DONE and set eq to the sticky match flag (1 if every nibble matched).
REQ-019 Otherwise, the block SHALL increment idx by 1 and remain in CMP; idx SHALL never exceed the registered len and SHALL never wrap.
REQ-020 In DONE, the block SHALL assert done=1 for exactly one cycle, hold busy=0, and return to IDLE unconditionally.
REQ-021 Latency: done SHALL assert (len+2) cycles after the start edge on a full scan, and (k+2) cycles after it on an early exit at nibble k.
REQ-022 eq and mis_idx SHALL hold their values from DONE until the next accepted start, then clear to 0 on that start.
REQ-023 start SHALL be ignored while in CMP or DONE; no request is queued.
REQ-024 Changes to a, b or len after acceptance SHALL NOT affect the comparison in progress.
REQ-025 cmp_a and cmp_b SHALL be 0 in IDLE and in DONE.

Reset
REQ-026 While rst=0, the block SHALL immediately enter IDLE and drive busy=0, done=0, eq=0, mis_idx=0, cmp_a=0, cmp_b=0, with idx and the operand registers cleared.
REQ-027 Asserting rst mid-CMP SHALL abort the comparison with no done pulse; the first start after rst returns to 1 SHALL behave as after power-up.

Verification
REQ-028 With a=16'h1234, b=16'h1234, len=3 and start pulsed, the bench SHALL see busy for 4 cycles, cmp pairs 4,3,2,1 in order, then done with eq=1 and mis_idx=0, 5 cycles after start.
REQ-029 With EARLY_EXIT=1, a=16'h1234, b=16'h1294, len=3, the bench SHALL see the scan stop after nibble 1, with done at cycle 3, eq=0 and mis_idx=1.
REQ-030 With EARLY_EXIT=0 and the same operands, the bench SHALL see all 4 nibbles scanned, with done at cycle 5, eq=0 and mis_idx=1 (not 2 or 3).
REQ-031 With a=16'hF00A, b=16'h000A, len=0, the bench SHALL see a single-nibble scan, with done at cycle 2 and eq=1 (upper nibbles ignored).
REQ-032 With start held high continuously and operands changed during CMP, the bench SHALL see back-to-back operations separated by a DONE and an IDLE cycle, with each result computed from the operands captured at acceptance.
REQ-033 With rst pulsed low during CMP, the bench SHALL see all outputs go to 0 immediately, with no done pulse, and the next start producing a correct fresh result.
